accum_alu: RTL and testbench

Parametrised accumulator ALU with a control state machine: an operand is loaded into a WIDTH-bit accumulator, then a stream of opcodes with operands is applied through a valid/ready handshake. Logic, add and sub complete in one cycle. MUL runs in an iterative shift-add sub-unit. Unsigned overflow raises a sticky error and forces a one-cycle ERROR state. It is the datapath/control core behind the board-level input and output muxing.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/accum_alu_if.sv | 29 ++
 rtl/shift_add_mult.sv | 62 ++++++
 rtl/accum_alu.sv | 130 +++++++++++++
 tb/tb_accum_alu.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator ALU: control states and opcodes.
package alu_pkg;

  localparam int SWIDTH = 2;
  localparam int OPW    = 3;

  typedef enum logic [SWIDTH-1:0] {
    S_OFF   = 2'b00,
    S_READY = 2'b01,
    S_RUN   = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  localparam logic [OPW-1:0] OP_AND  = 3'd0;
  localparam logic [OPW-1:0] OP_OR   = 3'd1;
  localparam logic [OPW-1:0] OP_XOR  = 3'd2;
  localparam logic [OPW-1:0] OP_NOT  = 3'd3;
  localparam logic [OPW-1:0] OP_ADD  = 3'd4;
  localparam logic [OPW-1:0] OP_SUB  = 3'd5;
  localparam logic [OPW-1:0] OP_MUL  = 3'd6;
  localparam logic [OPW-1:0] OP_RSVD = 3'd7;

endpackage

// File: rtl/accum_alu_if.sv
// Opcode/operand request bus and accumulator status bus of the accumulator ALU.
interface accum_alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic              on;
  logic              load;
  logic              op_valid;
  logic              op_ready;
  logic [OPW-1:0]    op;
  logic [WIDTH-1:0]  operand;
  logic [WIDTH-1:0]  acc;
  logic              res_valid;
  logic              error;
  logic [SWIDTH-1:0] state;

  modport master (
    output on, load, op_valid, op, operand,
    input  op_ready, acc, res_valid, error, state
  );

  modport slave (
    input  on, load, op_valid, op, operand,
    output op_ready, acc, res_valid, error, state
  );

endinterface

// File: rtl/shift_add_mult.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_prod_next;
  logic               w_last;

  // The final partial sum is presented combinationally so the caller can commit it
  // on the same edge that retires the last multiplier bit.
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  assign o_busy    = r_busy;
  assign o_done    = r_busy & w_last;
  assign o_product = w_prod_next;

  // Operand capture, iteration counting and partial-product accumulation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_prod   <= {(2*WIDTH){1'b0}};
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= {CW{1'b0}};
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= {(2*WIDTH){1'b0}};
    end
  end

endmodule

// File: rtl/accum_alu.sv
// Accumulator ALU core: control FSM, accumulator, single-cycle logic/arith ops,
// overflow detection and hand-off of MUL to the iterative multiplier.
module accum_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  accum_alu_if.slave  bus
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic               r_error;
  logic               r_res_valid;

  logic               w_op_ready;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic               w_mul_ovf;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_result;
  logic               w_ovf;
  logic               w_write;

  assign w_op_ready  = !i_rst && bus.on && (r_state == S_RUN) && !w_mul_busy && !bus.load;
  assign w_mul_start = w_op_ready && bus.op_valid && (bus.op == OP_MUL);
  assign w_mul_ovf   = |w_product[2*WIDTH-1:WIDTH];

  assign bus.op_ready  = w_op_ready;
  assign bus.acc       = r_acc;
  assign bus.res_valid = r_res_valid;
  assign bus.error     = r_error;
  assign bus.state     = r_state;

  shift_add_mult #(.WIDTH(WIDTH)) u_mult (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_mul_start),
    .i_abort   (!bus.on),
    .i_a       (r_acc),
    .i_b       (bus.operand),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // Single-cycle result and overflow; MUL and the reserved opcode never write here
  always_comb begin
    w_sum    = {1'b0, r_acc} + {1'b0, bus.operand};
    w_result = r_acc;
    w_ovf    = 1'b0;
    w_write  = 1'b0;
    case (bus.op)
      OP_AND: begin w_result = r_acc & bus.operand; w_write = 1'b1; end
      OP_OR:  begin w_result = r_acc | bus.operand; w_write = 1'b1; end
      OP_XOR: begin w_result = r_acc ^ bus.operand; w_write = 1'b1; end
      OP_NOT: begin w_result = ~r_acc;              w_write = 1'b1; end
      OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_ovf    = w_sum[WIDTH];
        w_write  = 1'b1;
      end
      OP_SUB: begin
        w_result = r_acc - bus.operand;
        w_ovf    = (r_acc < bus.operand);
        w_write  = 1'b1;
      end
      default: begin
        w_result = r_acc;
        w_ovf    = 1'b0;
        w_write  = 1'b0;
      end
    endcase
  end

  // Control FSM with accumulator, sticky error and result pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_READY;
      r_acc       <= {WIDTH{1'b0}};
      r_error     <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (!bus.on) begin
        r_state <= S_OFF;
      end else begin
        case (r_state)
          S_OFF: r_state <= S_READY;
          S_READY: begin
            if (bus.load) begin
              r_acc   <= bus.operand;
              r_error <= 1'b0;
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_mul_busy) begin
              if (w_mul_done) begin
                r_acc       <= w_product[WIDTH-1:0];
                r_res_valid <= 1'b1;
                if (w_mul_ovf) begin
                  r_error <= 1'b1;
                  r_state <= S_ERROR;
                end
              end
            end else if (bus.load) begin
              r_acc   <= bus.operand;
              r_error <= 1'b0;
            end else if (bus.op_valid && w_write) begin
              r_acc       <= w_result;
              r_res_valid <= 1'b1;
              if (w_ovf) begin
                r_error <= 1'b1;
                r_state <= S_ERROR;
              end
            end
          end
          S_ERROR: r_state <= S_READY;
          default: r_state <= S_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accum_alu.sv
// Bench for accum_alu: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a cycle-level behavioural model.
module tb_accum_alu;

  localparam int W = 8;
  localparam logic [1:0] ST_OFF = 2'b00, ST_READY = 2'b01, ST_RUN = 2'b10, ST_ERR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accum_alu_if #(.WIDTH(W)) u_if ();
  accum_alu #(.WIDTH(W)) u_dut (.i_clk(clk), .i_rst(rst), .bus(u_if));

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [1:0]     m_state = ST_READY;
  logic [W-1:0]   m_acc = '0;
  logic           m_err = 1'b0;
  logic           m_rv = 1'b0;
  int             m_left = 0;
  logic [2*W-1:0] m_prod = '0;
  logic           last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive inputs, check op_ready, advance the model, check registered outputs.
  task automatic cycle(input bit r, input bit o, input bit l, input bit v,
                       input logic [2:0] opc, input logic [W-1:0] d);
    bit exp_ready;
    int s;
    rst = r; u_if.on = o; u_if.load = l; u_if.op_valid = v; u_if.op = opc; u_if.operand = d;
    #1;
    exp_ready = !r && o && (m_state == ST_RUN) && (m_left == 0) && !l;
    last_ready = u_if.op_ready;
    chk("op_ready", {31'd0, u_if.op_ready}, {31'd0, exp_ready});
    if (r) begin
      m_state = ST_READY; m_acc = '0; m_err = 1'b0; m_rv = 1'b0; m_left = 0;
    end else begin
      m_rv = 1'b0;
      if (!o) begin
        m_state = ST_OFF; m_left = 0;
      end else if (m_state == ST_OFF) begin
        m_state = ST_READY;
      end else if (m_state == ST_ERR) begin
        m_state = ST_READY;
      end else if (m_state == ST_READY) begin
        if (l) begin m_acc = d; m_err = 1'b0; m_state = ST_RUN; end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_acc = m_prod[W-1:0]; m_rv = 1'b1;
          if (m_prod >= (2*W)'(1 << W)) begin m_err = 1'b1; m_state = ST_ERR; end
        end
      end else if (l) begin
        m_acc = d; m_err = 1'b0;
      end else if (v) begin
        case (opc)
          3'd0: begin m_acc = m_acc & d; m_rv = 1'b1; end
          3'd1: begin m_acc = m_acc | d; m_rv = 1'b1; end
          3'd2: begin m_acc = m_acc ^ d; m_rv = 1'b1; end
          3'd3: begin m_acc = ~m_acc;    m_rv = 1'b1; end
          3'd4: begin
            s = int'(m_acc) + int'(d);
            m_acc = W'(s); m_rv = 1'b1;
            if (s >= (1 << W)) begin m_err = 1'b1; m_state = ST_ERR; end
          end
          3'd5: begin
            s = int'(m_acc) - int'(d);
            m_acc = W'(s); m_rv = 1'b1;
            if (s < 0) begin m_err = 1'b1; m_state = ST_ERR; end
          end
          3'd6: begin m_prod = (2*W)'(m_acc) * (2*W)'(d); m_left = W; end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    chk("acc", {24'd0, u_if.acc}, {24'd0, m_acc});
    chk("res_valid", {31'd0, u_if.res_valid}, {31'd0, m_rv});
    chk("error", {31'd0, u_if.error}, {31'd0, m_err});
    chk("state", {30'd0, u_if.state}, {30'd0, m_state});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    int rv_cnt;
    int nrdy_cnt;
    u_if.on = 1'b0; u_if.load = 1'b0; u_if.op_valid = 1'b0; u_if.op = 3'd0; u_if.operand = '0;
    @(posedge clk); #1;

    // reset state
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("rst_state", {30'd0, u_if.state}, 32'd1);
    chk("rst_acc", {24'd0, u_if.acc}, 32'd0);

    // load 0x0F, OR 0xF0
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h0F);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'hF0);
    chk("or_acc", {24'd0, u_if.acc}, 32'hFF);
    chk("or_rv", {31'd0, u_if.res_valid}, 32'd1);
    chk("or_state", {30'd0, u_if.state}, 32'd2);
    idle(1);
    chk("or_rv_single", {31'd0, u_if.res_valid}, 32'd0);

    // ADD overflow: 200 + 100
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd200);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 8'd100);
    chk("add_acc", {24'd0, u_if.acc}, 32'd44);
    chk("add_err", {31'd0, u_if.error}, 32'd1);
    chk("add_state", {30'd0, u_if.state}, 32'd3);
    idle(1);
    chk("err_to_ready", {30'd0, u_if.state}, 32'd1);
    chk("err_sticky", {31'd0, u_if.error}, 32'd1);

    // load 12, MUL 11
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd12);
    chk("load_clr_err", {31'd0, u_if.error}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 8'd11);
    rv_cnt = 0; nrdy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      idle(1);
      if (!last_ready) nrdy_cnt++;
      if (u_if.res_valid) rv_cnt++;
      if (i == 7) chk("mul_acc_edge8", {24'd0, u_if.acc}, 32'd132);
    end
    chk("mul_busy_cycles", nrdy_cnt, 32'd8);
    chk("mul_rv_count", rv_cnt, 32'd1);

    // load 16, MUL 16 overflows to 0
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd16);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 8'd16);
    idle(8);
    chk("mul_ovf_acc", {24'd0, u_if.acc}, 32'd0);
    chk("mul_ovf_err", {31'd0, u_if.error}, 32'd1);
    idle(1);

    // SUB borrow, then NOT
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd5);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'd7);
    chk("sub_acc", {24'd0, u_if.acc}, 32'd254);
    chk("sub_err", {31'd0, u_if.error}, 32'd1);
    idle(1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd9);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 8'hAA);
    chk("not_acc", {24'd0, u_if.acc}, 32'hF6);
    chk("not_err", {31'd0, u_if.error}, 32'd0);

    // MUL aborted by on=0
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd12);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 8'd11);
    idle(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("abort_state", {30'd0, u_if.state}, 32'd0);
    chk("abort_acc", {24'd0, u_if.acc}, 32'd12);
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, (i > 2), 1'b0, 1'b0, 3'd0, 8'h00);
      if (u_if.res_valid) rv_cnt++;
    end
    chk("abort_no_rv", rv_cnt, 32'd0);

    // MUL aborted by rst
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd12);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 8'd11);
    idle(2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("rst_abort_acc", {24'd0, u_if.acc}, 32'd0);
    chk("rst_abort_state", {30'd0, u_if.state}, 32'd1);
    idle(10);

    // load and op_valid together in RUN
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h01);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 8'h33);
    chk("ld_op_ready", {31'd0, last_ready}, 32'd0);
    chk("ld_op_acc", {24'd0, u_if.acc}, 32'h33);
    chk("ld_op_rv", {31'd0, u_if.res_valid}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(24) != 0), ($urandom_range(5) == 0),
            1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
